uart_mmio: RTL and testbench

Memory-mapped UART peripheral with parametrised TX/RX FIFOs and a software-programmable baud divisor. It sits on the core's data bus beside DMemory and owns its register window. It replaces ad-hoc single-byte holding registers with buffered, flow-controlled channels and adds sticky error reporting.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_mmio.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared register map, STATUS bit indices and FSM state encodings
//            for the memory-mapped UART.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DIV_W = 16;

  localparam logic [3:0] c_OFF_DATA    = 4'h0;
  localparam logic [3:0] c_OFF_STATUS  = 4'h4;
  localparam logic [3:0] c_OFF_DIVISOR = 4'h8;

  localparam int c_ST_RX_VALID  = 0;
  localparam int c_ST_RX_FULL   = 1;
  localparam int c_ST_TX_FULL   = 2;
  localparam int c_ST_TX_EMPTY  = 3;
  localparam int c_ST_TX_BUSY   = 4;
  localparam int c_ST_RX_OVR    = 5;
  localparam int c_ST_FRAME_ERR = 6;
  localparam int c_ST_TX_OVF    = 7;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with extra-MSB pointers; a push into a full
//            FIFO is accepted when a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign head      = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_mmio.sv
// ============================================================================
// Module   : uart_mmio
// Purpose  : Memory-mapped UART with TX/RX FIFOs, programmable divisor and
//            sticky error flags driving a registered interrupt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR   = 32'h10010000,
  parameter int               FIFO_DEPTH  = 8,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd434,
  parameter int               SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

  logic [3:0]       w_off;
  logic             w_data_wr, w_data_rd, w_stat_wr, w_div_wr;
  logic [DIV_W-1:0] w_div_new;
  logic [DIV_W-1:0] r_div;
  logic             r_rx_ovr, r_frame_err, r_tx_ovf, r_irq;
  logic [7:0]       w_status;
  logic             w_unused;

  logic             w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic [7:0]       w_tx_head;
  logic             w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  logic [7:0]       w_rx_head;

  tx_state_t        r_tx_state, w_tx_next;
  logic [DIV_W-1:0] r_tx_cnt, r_tx_div;
  logic [2:0]       r_tx_bit;
  logic [7:0]       r_tx_shift;
  logic             r_tx, w_tx_load, w_tx_tick;

  rx_state_t        r_rx_state, w_rx_next;
  logic [DIV_W-1:0] r_rx_cnt, r_rx_div;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic [SYNC_STAGES-1:0] r_sync;
  logic             r_rx_prev, w_rx_s, w_rx_fall, w_rx_tick, w_frame_set;

  assign w_unused = &{1'b0, write_data[31:16], write_mask[3:2]};

  assign hit   = (address >= BASE_ADDR) && (address <= BASE_ADDR + 32'd15);
  assign w_off = address[3:0] - BASE_ADDR[3:0];

  assign w_data_wr = hit && write_enable && (w_off == c_OFF_DATA) && write_mask[0];
  assign w_data_rd = hit && read_enable && (w_off == c_OFF_DATA);
  assign w_stat_wr = hit && write_enable && (w_off == c_OFF_STATUS) && write_mask[0];
  assign w_div_wr  = hit && write_enable && (w_off == c_OFF_DIVISOR);
  assign w_div_new = {write_mask[1] ? write_data[15:8] : r_div[15:8],
                      write_mask[0] ? write_data[7:0]  : r_div[7:0]};

  assign w_tx_push = w_data_wr && !w_tx_full;
  assign w_rx_pop  = w_data_rd && !w_rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(w_tx_push), .din(write_data[7:0]), .pop(w_tx_pop),
    .full(w_tx_full), .empty(w_tx_empty), .head(w_tx_head)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(w_rx_push), .din(r_rx_shift), .pop(w_rx_pop),
    .full(w_rx_full), .empty(w_rx_empty), .head(w_rx_head)
  );

  always_comb begin
    w_status                 = '0;
    w_status[c_ST_RX_VALID]  = !w_rx_empty;
    w_status[c_ST_RX_FULL]   = w_rx_full;
    w_status[c_ST_TX_FULL]   = w_tx_full;
    w_status[c_ST_TX_EMPTY]  = w_tx_empty;
    w_status[c_ST_TX_BUSY]   = (r_tx_state != TX_IDLE) || !w_tx_empty;
    w_status[c_ST_RX_OVR]    = r_rx_ovr;
    w_status[c_ST_FRAME_ERR] = r_frame_err;
    w_status[c_ST_TX_OVF]    = r_tx_ovf;
  end

  always_comb begin
    read_data = '0;
    if (hit) begin
      case (w_off)
        c_OFF_DATA:    read_data = {24'b0, w_rx_empty ? 8'h00 : w_rx_head};
        c_OFF_STATUS:  read_data = {24'b0, w_status};
        c_OFF_DIVISOR: read_data = {16'b0, r_div};
        default:       read_data = '0;
      endcase
    end
  end

  // Sticky flags: a hardware set in the same cycle as a software clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= DEFAULT_DIV;
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_div_wr && (w_div_new >= 16'd2)) r_div <= w_div_new;
      if (w_rx_push && w_rx_full && !w_rx_pop) r_rx_ovr <= 1'b1;
      else if (w_stat_wr && write_data[c_ST_RX_OVR]) r_rx_ovr <= 1'b0;
      if (w_frame_set) r_frame_err <= 1'b1;
      else if (w_stat_wr && write_data[c_ST_FRAME_ERR]) r_frame_err <= 1'b0;
      if (w_data_wr && w_tx_full) r_tx_ovf <= 1'b1;
      else if (w_stat_wr && write_data[c_ST_TX_OVF]) r_tx_ovf <= 1'b0;
      r_irq <= !w_rx_empty || r_rx_ovr || r_frame_err || r_tx_ovf;
    end
  end

  assign irq = r_irq;
  assign tx  = r_tx;

  // STOP chains straight into START when more data is queued.
  assign w_tx_tick = (r_tx_cnt == '0);

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    w_tx_load = 1'b0;
    case (r_tx_state)
      TX_IDLE: if (!w_tx_empty) begin
        w_tx_pop  = 1'b1;
        w_tx_load = 1'b1;
        w_tx_next = TX_START;
      end
      TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_next = TX_STOP;
      TX_STOP: if (w_tx_tick) begin
        if (!w_tx_empty) begin
          w_tx_pop  = 1'b1;
          w_tx_load = 1'b1;
          w_tx_next = TX_START;
        end else begin
          w_tx_next = TX_IDLE;
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_div   <= DEFAULT_DIV;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_tx_load) begin
        r_tx_shift <= w_tx_head;
        r_tx_div   <= r_div;
        r_tx_cnt   <= r_div - 16'd1;
        r_tx_bit   <= '0;
      end else if (r_tx_state != TX_IDLE) begin
        if (w_tx_tick) begin
          r_tx_cnt <= r_tx_div - 16'd1;
          if (r_tx_state == TX_DATA) begin
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit   <= r_tx_bit + 3'd1;
          end
        end else begin
          r_tx_cnt <= r_tx_cnt - 16'd1;
        end
      end
      r_tx <= (r_tx_state == TX_START) ? 1'b0 :
              (r_tx_state == TX_DATA)  ? r_tx_shift[0] : 1'b1;
    end
  end

  assign w_rx_s    = r_sync[SYNC_STAGES-1];
  assign w_rx_fall = r_rx_prev && !w_rx_s;
  assign w_rx_tick = (r_rx_cnt == '0);

  always_comb begin
    w_rx_next   = r_rx_state;
    w_rx_push   = 1'b0;
    w_frame_set = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
      RX_START: if (w_rx_tick) w_rx_next = w_rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP: if (w_rx_tick) begin
        w_rx_next   = RX_IDLE;
        w_rx_push   = w_rx_s;
        w_frame_set = !w_rx_s;
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  // Half-bit wait after the edge puts every later sample mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync     <= '1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_div   <= DEFAULT_DIV;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], rx};
      r_rx_prev  <= w_rx_s;
      r_rx_state <= w_rx_next;
      if (r_rx_state == RX_IDLE) begin
        if (w_rx_fall) begin
          r_rx_div <= r_div;
          r_rx_cnt <= (r_div >> 1) - 16'd1;
          r_rx_bit <= '0;
        end
      end else if (w_rx_tick) begin
        r_rx_cnt <= r_rx_div - 16'd1;
        if (r_rx_state == RX_DATA) begin
          r_rx_shift <= {w_rx_s, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 3'd1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt - 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio.sv
// ============================================================================
// Module   : tb_uart_mmio
// Purpose  : Self-checking bench for uart_mmio with a byte scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_mmio;

  localparam logic [31:0] BASE = 32'h10010000;
  localparam logic [31:0] c_DATA = 32'h0, c_STAT = 32'h4, c_DIV = 32'h8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, write_data, read_data;
  logic [3:0]  write_mask;
  logic        write_enable, read_enable, hit, tx, irq;
  logic        loop, rx_drv, rx_w;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] seen_q[$];
  int         fall_q[$];
  logic       mon_en = 1'b0;
  logic       log_en = 1'b0;
  int         mon_div = 100;

  assign rx_w = loop ? tx : rx_drv;

  uart_mmio #(
    .BASE_ADDR(BASE), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd434), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .write_mask(write_mask), .write_enable(write_enable), .read_enable(read_enable),
    .read_data(read_data), .hit(hit), .tx(tx), .rx(rx_w), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic peek(input logic [31:0] off, output logic [31:0] d);
    address = BASE + off;
    #1 d = read_data;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    address = BASE + off; write_data = d; write_mask = m; write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d);
    @(negedge clk);
    address = BASE + off; read_enable = 1'b1;
    #1 d = read_data;
    @(negedge clk);
    read_enable = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    logic [31:0] s;
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      peek(c_STAT, s);
      if (!s[4]) done = 1'b1;
    end
    chk("tx_idle_wait", 32'(done), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_b, input int div);
    logic [9:0] fr;
    fr = {stop_b, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      repeat (div) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  // Line decoder: samples each bit mid-period at mon_div clocks per bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clk); #1;
      if (mon_en && tx == 1'b0) begin
        repeat (mon_div / 2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (mon_div) @(posedge clk);
          #1 b[i] = tx;
        end
        repeat (mon_div) @(posedge clk);
        seen_q.push_back(b);
      end
    end
  end

  initial begin
    int   cyc = 0;
    logic tx_prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (log_en && tx_prev && !tx) fall_q.push_back(cyc);
      tx_prev = tx;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  pat;
    logic        e;

    rst = 1'b1; address = BASE; write_data = '0; write_mask = '0;
    write_enable = 1'b0; read_enable = 1'b0; loop = 1'b0; rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    peek(c_STAT, d); chk("rst_status", d, 32'h08);
    peek(c_DIV, d);  chk("rst_div", d, 32'd434);
    peek(32'hC, d);  chk("unmapped_read", d, 32'd0);
    address = BASE + 32'd16; #1 chk("hit_outside", 32'(hit), 32'd0);

    // Single byte at divisor 4, cycle-exact line check.
    wr(c_DIV, 32'd4, 4'b0011);
    peek(c_DIV, d); chk("div_4", d, 32'd4);
    pat = 8'hA5;
    @(negedge clk);
    address = BASE + c_DATA; write_data = 32'hA5; write_mask = 4'b0001; write_enable = 1'b1;
    @(posedge clk); #1 write_enable = 1'b0;
    @(posedge clk); #1 chk("tx_before_start", 32'(tx), 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      e = (k < 4) ? 1'b0 : (k < 36) ? pat[(k - 4) / 4] : 1'b1;
      chk("tx_line", 32'(tx), 32'(e));
      if (k == 20) begin peek(c_STAT, d); chk("busy_mid", 32'(d[4]), 32'd1); end
    end
    @(posedge clk); #1;
    peek(c_STAT, d); chk("busy_after_40", 32'(d[4]), 32'd0);

    // Loopback of three bytes.
    wr(c_DIV, 32'd16, 4'b0011);
    loop = 1'b1;
    foreach (pat[i]) ; // no-op keeps pat in scope
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b;
      b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h3C;
      wr(c_DATA, 32'(b), 4'b0001);
      exp_q.push_back(b);
    end
    wait_idle(2000);
    repeat (20) @(negedge clk);
    peek(c_STAT, d); chk("rx_valid", 32'(d[0]), 32'd1);
    chk("irq_rx", 32'(irq), 32'd1);
    for (int i = 0; i < 3; i++) begin
      rd(c_DATA, d);
      chk("loop_byte", d, 32'(exp_q.pop_front()));
    end
    rd(c_DATA, d); chk("empty_read", d, 32'd0);
    peek(c_STAT, d); chk("status_after_drain", d, 32'h08);

    // Nine bytes into an 8-deep RX FIFO without reading.
    for (int i = 0; i < 9; i++) begin
      logic [7:0] b;
      b = 8'(i * 29 + 7);
      wr(c_DATA, 32'(b), 4'b0001);
      if (i < 8) exp_q.push_back(b);
    end
    wait_idle(3000);
    repeat (20) @(negedge clk);
    peek(c_STAT, d);
    chk("rx_full", 32'(d[1]), 32'd1);
    chk("rx_overrun", 32'(d[5]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      rd(c_DATA, d);
      chk("ovr_byte", d, 32'(exp_q.pop_front()));
    end
    wr(c_STAT, 32'h20, 4'b0001);
    peek(c_STAT, d); chk("ovr_cleared", d, 32'h08);

    // Overfilled TX FIFO while a frame is in flight.
    loop = 1'b0;
    wr(c_DIV, 32'd100, 4'b0011);
    mon_div = 100; mon_en = 1'b1;
    wr(c_DATA, 32'h11, 4'b0001);
    exp_q.push_back(8'h11);
    @(negedge clk);
    address = BASE + c_DATA; write_mask = 4'b0001; write_enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      write_data = 32'h20 + 32'(i);
      if (i < 8) exp_q.push_back(8'(8'h20 + i));
      @(negedge clk);
    end
    write_enable = 1'b0;
    peek(c_STAT, d); chk("tx_ovf", 32'(d[7]), 32'd1);
    wait_idle(12000);
    repeat (10) @(negedge clk);
    mon_en = 1'b0;
    chk("tx_frame_count", 32'(seen_q.size()), 32'd9);
    while (seen_q.size() > 0 && exp_q.size() > 0)
      chk("tx_byte", 32'(seen_q.pop_front()), 32'(exp_q.pop_front()));
    seen_q.delete(); exp_q.delete();
    wr(c_STAT, 32'h80, 4'b0001);
    peek(c_STAT, d); chk("ovf_cleared", d, 32'h08);

    // Framing error, glitch rejection, then a clean externally driven byte.
    wr(c_DIV, 32'd16, 4'b0011);
    @(negedge clk);
    send_rx(8'h55, 1'b0, 16);
    repeat (20) @(negedge clk);
    peek(c_STAT, d);
    chk("frame_err", 32'(d[6]), 32'd1);
    chk("frame_no_push", 32'(d[0]), 32'd0);
    chk("irq_frame", 32'(irq), 32'd1);
    wr(c_STAT, 32'h40, 4'b0001);
    repeat (3) @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'd0);
    rx_drv = 1'b0; @(negedge clk); rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    peek(c_STAT, d); chk("glitch_ignored", d, 32'h08);
    exp_q.push_back(8'hC3);
    send_rx(8'hC3, 1'b1, 16);
    repeat (20) @(negedge clk);
    rd(c_DATA, d); chk("ext_byte", d, 32'(exp_q.pop_front()));

    // Divisor rules.
    wr(c_DIV, 32'd1, 4'b0011);
    peek(c_DIV, d); chk("div_reject_1", d, 32'd16);
    wr(c_DIV, 32'h0300, 4'b0010);
    peek(c_DIV, d); chk("div_lane_mask", d, 32'h0310);

    // Divisor change mid-frame only affects later frames.
    wr(c_DIV, 32'd4, 4'b0011);
    fall_q.delete(); log_en = 1'b1;
    for (int i = 0; i < 3; i++) wr(c_DATA, 32'hFF, 4'b0001);
    repeat (8) @(negedge clk);
    wr(c_DIV, 32'd8, 4'b0011);
    wait_idle(1000);
    log_en = 1'b0;
    chk("fall_count", 32'(fall_q.size()), 32'd3);
    if (fall_q.size() == 3) begin
      chk("frame_len_old", 32'(fall_q[1] - fall_q[0]), 32'd40);
      chk("frame_len_new", 32'(fall_q[2] - fall_q[1]), 32'd80);
    end

    // Reset in the middle of a frame.
    wr(c_DATA, 32'h00, 4'b0001);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tx", 32'(tx), 32'd1);
    peek(c_STAT, d); chk("midrst_status", d, 32'h08);
    peek(c_DIV, d);  chk("midrst_div", d, 32'd434);
    chk("midrst_irq", 32'(irq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
